// File: rtl/demux_serial_driver_if.sv
// Request/response bundle between a frame source and demux_serial_driver.
// The master side issues frame requests; the slave side drives the demux lines.
interface demux_serial_driver_if #(
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_dest;
    logic [DATA_W-1:0] req_data;
    logic [1:0]        sel;
    logic              dout;
    logic              frame;
    logic              done;

    modport master (
        output req_valid, req_dest, req_data,
        input  req_ready, sel, dout, frame, done
    );

    modport slave (
        input  req_valid, req_dest, req_data,
        output req_ready, sel, dout, frame, done
    );
endinterface

// File: rtl/demux_serial_driver.sv
// Serialises one request into a frame (start bit, DATA_W payload bits MSB
// first, GAP idle cycles) on a single line that feeds a 1x4 demux.  The demux
// select is latched at accept time and held for the whole frame.
module demux_serial_driver #(
    parameter int DATA_W = 8,
    parameter int GAP    = 1
) (
    input logic              clk,
    input logic              rst_n,
    demux_serial_driver_if.slave bus
);
    // Wide enough for DATA_W-1 (max 31) and GAP-1 (max 14).
    localparam int CW = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        sel_q, sel_d;
    logic              dout_q, dout_d;
    logic              frame_q, frame_d;
    logic              done_q, done_d;

    // Ready is gated by reset so nothing is accepted on a reset edge.
    assign bus.req_ready = (state_q == ST_IDLE) && rst_n;
    assign bus.sel       = sel_q;
    assign bus.dout      = dout_q;
    assign bus.frame     = frame_q;
    assign bus.done      = done_q;

    // Next state plus next line values; outputs are registered, so each branch
    // computes what the line shows in the state being entered.  The payload
    // register shifts left so its MSB is always the next bit to send.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        sel_d   = sel_q;
        dout_d  = 1'b0;
        frame_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_d = ST_START;
                    data_d  = bus.req_data;
                    sel_d   = bus.req_dest;
                    dout_d  = 1'b1;
                    frame_d = 1'b1;
                end
            end
            ST_START: begin
                state_d = ST_SHIFT;
                cnt_d   = CW'(DATA_W - 1);
                dout_d  = data_q[DATA_W-1];
                data_d  = data_q << 1;
                frame_d = 1'b1;
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d   = cnt_q - CW'(1);
                    dout_d  = data_q[DATA_W-1];
                    data_d  = data_q << 1;
                    frame_d = 1'b1;
                end else if (GAP > 0) begin
                    state_d = ST_GAP;
                    cnt_d   = CW'(GAP - 1);
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset; a reset
    // mid-frame drops straight to IDLE without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            sel_q   <= 2'b00;
            dout_q  <= 1'b0;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            dout_q  <= dout_d;
            frame_q <= frame_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_demux_serial_driver.sv
// Bench for demux_serial_driver: directed frame scenarios on an 8-bit/GAP=1
// instance and a 4-bit/GAP=0 instance, then randomized traffic on both checked
// against a timeline model of the frame format.
module tb_demux_serial_driver;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    demux_serial_driver_if #(.DATA_W(8)) b8 ();
    demux_serial_driver_if #(.DATA_W(4)) b4 ();

    demux_serial_driver #(.DATA_W(8), .GAP(1)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    demux_serial_driver #(.DATA_W(4), .GAP(0)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    always #5 clk = ~clk;

    // Expected {ready, dout, frame, done} in the k-th cycle after an accept
    // edge (k=1 is the start bit).  Frame period is dw+2+gap cycles.
    function automatic logic [3:0] frame_exp(input logic [31:0] d, input int dw,
                                             input int gap, input int k);
        if (k == 1) return 4'b0110;
        if (k <= dw + 1) return {1'b0, d[dw-1-(k-2)], 1'b1, 1'b0};
        if (k <= dw + 1 + gap) return 4'b0000;
        return {1'b1, 1'b0, 1'b0, (k == dw + 2 + gap)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        b8.req_valid = 1'b1; b8.req_dest = 2'd3; b8.req_data = 8'hFF;
        b4.req_valid = 1'b1; b4.req_dest = 2'd3; b4.req_data = 4'hF;
        repeat (2) @(negedge clk);
        total++; if (b8.req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", b8.req_ready); end
        total++; if (b8.sel !== 2'd0) begin bad++; $display("FAIL rst_sel got=%0d want=0", b8.sel); end
        total++; if ({b8.dout, b8.frame, b8.done} !== 3'b000) begin bad++; $display("FAIL rst_lines got=%b want=000", {b8.dout, b8.frame, b8.done}); end
        total++; if ({b4.req_ready, b4.dout, b4.frame, b4.done} !== 4'b0000) begin bad++; $display("FAIL rst_b4 got=%b want=0000", {b4.req_ready, b4.dout, b4.frame, b4.done}); end
        rst_n = 1'b1;
        b8.req_valid = 1'b0;
        b4.req_valid = 1'b0;
        #1;
        total++; if (b8.req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b want=1", b8.req_ready); end
        @(negedge clk);
        total++; if ({b8.frame, b8.dout} !== 2'b00) begin bad++; $display("FAIL rst_no_accept got=%b want=00", {b8.frame, b8.dout}); end
    endtask

    task automatic test_single();
        logic [10:0] ed = 11'b11010010100;
        logic [10:0] ef = 11'b11111111100;
        b8.req_valid = 1'b1; b8.req_dest = 2'd2; b8.req_data = 8'hA5;
        for (int j = 1; j <= 11; j++) begin
            @(negedge clk);
            total++; if (b8.dout !== ed[11-j]) begin bad++; $display("FAIL single_dout j=%0d got=%b want=%b", j, b8.dout, ed[11-j]); end
            total++; if (b8.frame !== ef[11-j]) begin bad++; $display("FAIL single_frame j=%0d got=%b want=%b", j, b8.frame, ef[11-j]); end
            total++; if (b8.done !== (j == 11)) begin bad++; $display("FAIL single_done j=%0d got=%b want=%b", j, b8.done, (j == 11)); end
            total++; if (b8.sel !== 2'd2) begin bad++; $display("FAIL single_sel j=%0d got=%0d want=2", j, b8.sel); end
            if (j == 1) begin b8.req_valid = 1'b0; b8.req_data = 8'h00; end
        end
    endtask

    task automatic test_back_to_back();
        b8.req_valid = 1'b1; b8.req_dest = 2'd0; b8.req_data = 8'hFF;
        for (int j = 1; j <= 22; j++) begin
            @(negedge clk);
            if (j <= 11) begin
                total++; if (b8.sel !== 2'd0) begin bad++; $display("FAIL b2b_sel0 j=%0d got=%0d want=0", j, b8.sel); end
            end
            if (j >= 1 && j <= 9) begin
                total++; if ({b8.dout, b8.frame} !== 2'b11) begin bad++; $display("FAIL b2b_first j=%0d got=%b want=11", j, {b8.dout, b8.frame}); end
            end
            if (j == 11) begin
                total++; if ({b8.done, b8.req_ready} !== 2'b11) begin bad++; $display("FAIL b2b_done_ready got=%b want=11", {b8.done, b8.req_ready}); end
                b8.req_dest = 2'd3; b8.req_data = 8'h00;
            end
            if (j == 12) begin
                total++; if ({b8.sel, b8.dout, b8.frame} !== 4'b1111) begin bad++; $display("FAIL b2b_second_start got=%b want=1111", {b8.sel, b8.dout, b8.frame}); end
                b8.req_valid = 1'b0;
            end
            if (j >= 13 && j <= 20) begin
                total++; if ({b8.dout, b8.frame, b8.sel} !== 4'b0111) begin bad++; $display("FAIL b2b_second j=%0d got=%b want=0111", j, {b8.dout, b8.frame, b8.sel}); end
            end
            if (j == 22) begin
                total++; if (b8.done !== 1'b1) begin bad++; $display("FAIL b2b_done2 got=%b want=1", b8.done); end
            end
        end
    endtask

    task automatic test_all_dest();
        for (int d = 0; d < 4; d++) begin
            logic [7:0] data = 8'(d + 1);
            b8.req_valid = 1'b1; b8.req_dest = 2'(d); b8.req_data = data;
            for (int j = 1; j <= 11; j++) begin
                @(negedge clk);
                if (j == 1) begin
                    total++; if (b8.sel !== 2'(d)) begin bad++; $display("FAIL dest_sel d=%0d got=%0d want=%0d", d, b8.sel, d); end
                    b8.req_valid = 1'b0;
                end
                if (j == 9) begin
                    total++; if (b8.dout !== data[0]) begin bad++; $display("FAIL dest_lsb d=%0d got=%b want=%b", d, b8.dout, data[0]); end
                end
                if (j == 11) begin
                    total++; if (b8.done !== 1'b1) begin bad++; $display("FAIL dest_done d=%0d got=%b want=1", d, b8.done); end
                end
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [3:0] e;
        b8.req_valid = 1'b1; b8.req_dest = 2'd2; b8.req_data = 8'h81;
        for (int j = 1; j <= 22; j++) begin
            @(negedge clk);
            e = frame_exp(32'h81, 8, 1, j);
            total++; if ({b8.dout, b8.frame, b8.done} !== e[2:0]) begin bad++; $display("FAIL busy_lines j=%0d got=%b want=%b", j, {b8.dout, b8.frame, b8.done}, e[2:0]); end
            total++; if (b8.sel !== 2'd2) begin bad++; $display("FAIL busy_sel j=%0d got=%0d want=2", j, b8.sel); end
            if (j == 1) b8.req_valid = 1'b0;
            if (j == 4) begin b8.req_valid = 1'b1; b8.req_dest = 2'd1; b8.req_data = 8'h3C; end
            if (j == 5) b8.req_valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d = 8'($urandom);
        b8.req_valid = 1'b1; b8.req_dest = 2'd1; b8.req_data = d;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (j == 1) b8.req_valid = 1'b0;
            if (j >= 2 && j <= 5) begin
                total++; if (b8.dout !== d[9-j]) begin bad++; $display("FAIL rmid_bit j=%0d got=%b want=%b", j, b8.dout, d[9-j]); end
            end
            if (j == 5) rst_n = 1'b0;
            if (j == 6) begin
                total++; if (b8.req_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready_low got=%b want=0", b8.req_ready); end
                rst_n = 1'b1;
            end
            if (j == 7) begin
                total++; if ({b8.sel, b8.dout, b8.frame, b8.done} !== 5'b00000) begin bad++; $display("FAIL rmid_clear got=%b want=00000", {b8.sel, b8.dout, b8.frame, b8.done}); end
            end
            if (j == 8) begin
                total++; if ({b8.req_ready, b8.done, b8.frame} !== 3'b100) begin bad++; $display("FAIL rmid_after got=%b want=100", {b8.req_ready, b8.done, b8.frame}); end
            end
        end
    endtask

    task automatic test_gap0();
        logic [3:0] d1 = 4'($urandom);
        logic [3:0] d2 = 4'($urandom);
        b4.req_valid = 1'b1; b4.req_dest = 2'd1; b4.req_data = d1;
        for (int j = 1; j <= 13; j++) begin
            @(negedge clk);
            if (j >= 2 && j <= 5) begin
                total++; if ({b4.dout, b4.frame} !== {d1[5-j], 1'b1}) begin bad++; $display("FAIL gap0_bit1 j=%0d got=%b want=%b", j, {b4.dout, b4.frame}, {d1[5-j], 1'b1}); end
            end
            if (j == 6) begin
                total++; if ({b4.done, b4.req_ready, b4.frame} !== 3'b110) begin bad++; $display("FAIL gap0_done got=%b want=110", {b4.done, b4.req_ready, b4.frame}); end
                b4.req_dest = 2'd2; b4.req_data = d2;
            end
            if (j == 7) begin
                total++; if ({b4.sel, b4.dout, b4.frame} !== 4'b1011) begin bad++; $display("FAIL gap0_start2 got=%b want=1011", {b4.sel, b4.dout, b4.frame}); end
                b4.req_valid = 1'b0;
            end
            if (j >= 8 && j <= 11) begin
                total++; if (b4.dout !== d2[11-j]) begin bad++; $display("FAIL gap0_bit2 j=%0d got=%b want=%b", j, b4.dout, d2[11-j]); end
            end
            if (j == 12 || j == 13) begin
                total++; if ({b4.done, b4.frame} !== {(j == 12), 1'b0}) begin bad++; $display("FAIL gap0_end j=%0d got=%b want=%b", j, {b4.done, b4.frame}, {(j == 12), 1'b0}); end
            end
        end
    endtask

    // Random traffic on both instances; each model tracks only the cycles
    // since the last accepted request plus the latched dest/data.
    task automatic test_random();
        int         k8 = 1000, k4 = 1000;
        logic [7:0] m8_data = '0;
        logic [3:0] m4_data = '0;
        logic [1:0] m8_sel = 2'd0, m4_sel = 2'd2;
        logic [3:0] e8, e4;
        logic       v8, v4;
        logic [1:0] dst8, dst4;
        logic [7:0] dat8;
        logic [3:0] dat4;
        for (int c = 0; c < 500; c++) begin
            e8 = frame_exp({24'b0, m8_data}, 8, 1, k8);
            e4 = frame_exp({28'b0, m4_data}, 4, 0, k4);
            total++; if ({b8.req_ready, b8.dout, b8.frame, b8.done} !== e8) begin bad++; $display("FAIL rand8_lines c=%0d got=%b want=%b", c, {b8.req_ready, b8.dout, b8.frame, b8.done}, e8); end
            total++; if (b8.sel !== m8_sel) begin bad++; $display("FAIL rand8_sel c=%0d got=%0d want=%0d", c, b8.sel, m8_sel); end
            total++; if ({b4.req_ready, b4.dout, b4.frame, b4.done} !== e4) begin bad++; $display("FAIL rand4_lines c=%0d got=%b want=%b", c, {b4.req_ready, b4.dout, b4.frame, b4.done}, e4); end
            total++; if (b4.sel !== m4_sel) begin bad++; $display("FAIL rand4_sel c=%0d got=%0d want=%0d", c, b4.sel, m4_sel); end
            v8 = ($urandom_range(0, 2) != 0); dst8 = 2'($urandom); dat8 = 8'($urandom);
            v4 = ($urandom_range(0, 2) != 0); dst4 = 2'($urandom); dat4 = 4'($urandom);
            b8.req_valid = v8; b8.req_dest = dst8; b8.req_data = dat8;
            b4.req_valid = v4; b4.req_dest = dst4; b4.req_data = dat4;
            if (e8[3] && v8) begin m8_sel = dst8; m8_data = dat8; k8 = 1; end
            else if (k8 < 1000) k8++;
            if (e4[3] && v4) begin m4_sel = dst4; m4_data = dat4; k4 = 1; end
            else if (k4 < 1000) k4++;
            @(negedge clk);
        end
        b8.req_valid = 1'b0;
        b4.req_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        b8.req_valid = 1'b0; b8.req_dest = 2'd0; b8.req_data = '0;
        b4.req_valid = 1'b0; b4.req_dest = 2'd0; b4.req_data = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_all_dest();
        test_busy_ignore();
        test_reset_mid();
        test_gap0();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/demux_serial_driver.md
DEMUX_SERIAL_DRIVER -- requirements
Module: demux_serial_driver

Interface
REQ-001 Parameter DATA_W, default 8: payload bits per frame; legal range 1..32.
REQ-002 Parameter GAP, default 1: idle cycles after each frame; legal range 0..15.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low; sampled on the rising edge of clk only.
REQ-005 req_valid  input  1  request to send one frame.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_dest  input  2  destination output of the downstream 1x4 demux (0..3).
REQ-008 req_data  input  DATA_W  payload, sent MSB first.
REQ-009 sel  output  2  registered select to the downstream 1x4 demux.
REQ-010 dout  output  1  registered serial line to the demux data input.
REQ-011 frame  output  1  high while dout carries the start bit or a payload bit.
REQ-012 done  output  1  one-cycle pulse on frame completion.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, START, SHIFT and GAP.
REQ-014 req_ready SHALL equal (state==IDLE && rst_n==1), combinationally.
REQ-015 Accept occurs on an edge where req_valid && req_ready; the block SHALL latch req_dest and req_data at that edge and SHALL load sel with req_dest.
REQ-016 The block SHALL go IDLE->START on accept; START holds for 1 cycle with dout=1 and frame=1.
REQ-017 In SHIFT, the block SHALL drive payload bits MSB first, one bit per cycle for DATA_W cycles, with frame=1.
REQ-018 After the last bit, the block SHALL go SHIFT->GAP if GAP>0, or SHIFT->IDLE if GAP==0.
REQ-019 GAP SHALL last exactly GAP cycles with dout=0, frame=0 and sel held; the block then returns to IDLE.
REQ-020 Timing from an accept edge T: the start bit SHALL appear at T+1, bit i (MSB=DATA_W-1) at T+2+(DATA_W-1-i), and IDLE SHALL be re-entered at T+2+DATA_W+GAP.
REQ-021 done SHALL be 1 for exactly the first IDLE cycle after a completed frame and 0 at all other times.
REQ-022 With req_valid held high, back-to-back frames SHALL start in the same cycle done is high, because req_ready is also high then; the frame period is 2+DATA_W+GAP cycles.
REQ-023 sel SHALL remain constant from the START cycle through the last GAP cycle, and SHALL keep its last value while IDLE.
REQ-024 In IDLE, dout SHALL be 0 and frame SHALL be 0.
REQ-025 req_valid, req_dest and req_data SHALL be ignored outside IDLE; requests are not queued.
REQ-026 X on req_dest or req_data while req_valid=0 SHALL NOT propagate into sel or dout.

Reset
REQ-027 On an edge where rst_n=0, the block SHALL set state=IDLE, sel=2'b00, dout=0, frame=0, done=0, the bit counter to 0 and the latched data to 0.
REQ-028 req_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release.
REQ-029 Reset in any non-IDLE state SHALL abort the frame with no done pulse; no further payload bits SHALL be emitted.
REQ-030 If rst_n=0 and req_valid=1 on the same edge, no frame SHALL be accepted.

Verification
REQ-031 Single frame (DATA_W=8, GAP=1): accept dest=2, data=8'hA5 at edge T -> sel=2 from T+1; dout at T+1..T+9 = 1,1,0,1,0,0,1,0,1; frame high T+1..T+9; dout=0 at T+10; done=1 at T+11.
REQ-032 Back-to-back: req_valid held high with dest=0/data=8'hFF, then dest=3/data=8'h00 -> second start bit exactly 11 cycles after the first; sel changes 0->3 only at the second start bit.
REQ-033 All four destinations in turn, data 8'h01..8'h04 -> sel sequence 0,1,2,3; each frame's last payload bit equals the data LSB.
REQ-034 Busy-ignore: pulse req_valid with dest=1/data=8'h3C during SHIFT of an 8'h81 frame -> the 8'h81 frame completes unchanged; no 8'h3C frame is ever sent.
REQ-035 Reset mid-frame: rst_n=0 for 1 cycle after the 4th payload bit -> next cycle sel=0, dout=0, frame=0, done=0; req_ready=1 in the following cycle.
REQ-036 GAP=0, DATA_W=4: two accepts with req_valid held high -> frame period is 6 cycles and done coincides with the next accept.
